shift_seq8: RTL



---
 rtl/shift_seq8_if.sv | 27 ++
 rtl/shift_seq8.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/shift_seq8_if.sv
// Command/result bundle between a shift_seq8 sequencer and its requester,
// plus the strobes that drive a slaved universal shift register.
interface shift_seq8_if;
  logic       start;
  logic [1:0] op;
  logic [2:0] amount;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       carry;
  logic [1:0] mode;
  logic       shift_en;
  logic       ser_r;
  logic       ser_l;
  logic [7:0] pin;

  modport master (
    output start, op, amount, din,
    input  busy, done, dout, carry, mode, shift_en, ser_r, ser_l, pin
  );

  modport slave (
    input  start, op, amount, din,
    output busy, done, dout, carry, mode, shift_en, ser_r, ser_l, pin
  );
endinterface

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer: one bit per clock, with mode/enable strobes for a slaved shift register.
// Define SHIFT_SEQ_ROTATE_EN to build ROR (op=11); otherwise op=11 completes immediately with dout=din.
module shift_seq8 (
  input  logic        clock,
  input  logic        reset,
  shift_seq8_if.slave bus
);
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [W-1:0]   work;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_q;
  logic [W-1:0]   dout_q;
  logic           carry_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   work_nx;
  logic           out_bit;
  logic           fill_r;
  logic           direct;

  // One-bit step of the working register and the bit it pushes out
  always_comb begin
    work_nx = work;
    out_bit = 1'b0;
    fill_r  = 1'b0;
    case (op_q)
      OP_SLL: begin
        work_nx = {work[W-2:0], 1'b0};
        out_bit = work[W-1];
      end
      OP_SRL: begin
        work_nx = {1'b0, work[W-1:1]};
        out_bit = work[0];
      end
      OP_SRA: begin
        work_nx = {work[W-1], work[W-1:1]};
        out_bit = work[0];
        fill_r  = work[W-1];
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR: begin
        work_nx = {work[0], work[W-1:1]};
        out_bit = work[0];
        fill_r  = work[0];
      end
`endif
      default: ;
    endcase
  end

  // Commands that need no shift cycles go straight to DONE
  always_comb begin
`ifdef SHIFT_SEQ_ROTATE_EN
    direct = (bus.amount == '0);
`else
    direct = (bus.amount == '0) || (bus.op == OP_ROR);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      op_q    <= OP_SLL;
      dout_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work    <= bus.din;
            cnt     <= bus.amount;
            op_q    <= bus.op;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            if (direct) begin
              state  <= DONE;
              done_q <= 1'b1;
              dout_q <= bus.din;
            end else begin
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= DONE;
            done_q  <= 1'b1;
            dout_q  <= work_nx;
            carry_q <= out_bit;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-register strobes, valid ahead of each rising edge
  always_comb begin
    bus.mode     = MODE_HOLD;
    bus.shift_en = 1'b0;
    bus.ser_r    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bus.mode     = MODE_LOAD;
          bus.shift_en = 1'b1;
        end
      end
      SHIFT: begin
        bus.mode     = (op_q == OP_SLL) ? MODE_LEFT : MODE_RIGHT;
        bus.shift_en = 1'b1;
        bus.ser_r    = fill_r;
      end
      default: ;
    endcase
  end

  assign bus.ser_l = 1'b0;
  assign bus.pin   = bus.din;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign bus.carry = carry_q;
endmodule
